// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg : shared types and lane helpers for the memory-access unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUS   = 2'b01,
        RESP  = 2'b10,
        FAULT = 2'b11
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e s);
        return 4'(1) << s;
    endfunction

    // Eight lanes covers XLEN=64; narrower buses keep the low bits.
    function automatic logic [7:0] byte_enable(input size_e s, input logic [2:0] off);
        logic [15:0] m;
        m = (16'(1) << size_bytes(s)) - 16'd1;
        m = m << off;
        return m[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_unit_if.sv
// ============================================================================
// mem_bus_unit_if : core request/response and memory bus signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_bus_unit_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [1:0]        size;
    logic              sign;
    logic [XLEN-1:0]   rdata;
    logic              done;
    logic              err;
    logic              busy;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN/8-1:0] bus_be;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_err;

    modport slave (
        input  req, we, addr, wdata, size, sign, bus_ready, bus_rdata, bus_err,
        output rdata, done, err, busy, bus_valid, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req, we, addr, wdata, size, sign, bus_ready, bus_rdata, bus_err,
        input  rdata, done, err, busy, bus_valid, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_unit_load_extend.sv
// ============================================================================
// load_extend : shift captured bus word down to the access lane, mask, extend
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extend
    import mem_bus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           data_i,
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  size_e                     size_i,
    input  logic                      sign_i,
    output logic [XLEN-1:0]           data_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top_bit;
    int unsigned     nbits;

    always_comb begin
        shifted = data_i >> {off_i, 3'b000};
        nbits   = 8 * int'(size_bytes(size_i));
        mask    = '1;
        top_bit = '0;
        data_o  = shifted;
        if (nbits < XLEN) begin
            mask    = (XLEN'(1) << nbits) - XLEN'(1);
            top_bit = XLEN'(1) << (nbits - 1);
            data_o  = (shifted & mask) | ((sign_i && |(shifted & top_bit)) ? ~mask : '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_unit.sv
// ============================================================================
// mem_bus_unit : valid/ready memory-access unit with lane steering and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_unit
    import mem_bus_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_bus_unit_if.slave mem_io
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int CNTW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              we_q, sign_q;
    size_e             size_q;
    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [BYTES-1:0]  be_q;

    logic              accept;
    size_e             req_size;
    logic [OFFW-1:0]   req_off;
    logic [OFFW-1:0]   req_amask;
    logic              req_ok;
    logic [BYTES-1:0]  req_be;
    logic [XLEN-1:0]   req_wdata;
    logic              timeout_hit;
    logic [XLEN-1:0]   ext_data;

    assign req_size  = size_e'(mem_io.size);
    assign req_off   = mem_io.addr[OFFW-1:0];
    assign req_amask = OFFW'(size_bytes(req_size) - 4'd1);
    // Double-word only exists on a 64-bit bus.
    assign req_ok    = ((req_off & req_amask) == '0) && !((req_size == SZ_D) && (XLEN == 32));
    assign req_be    = BYTES'(byte_enable(req_size, 3'(req_off)));
    assign req_wdata = mem_io.wdata << {req_off, 3'b000};
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_io.req) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = req_ok ? BUS : FAULT;
                end
            end
            BUS: begin
                // A handshake in the last allowed cycle still completes normally.
                if (mem_io.bus_ready) begin
                    rdata_d = mem_io.bus_rdata;
                    err_d   = mem_io.bus_err;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= mem_io.we;
            sign_q  <= mem_io.sign;
            size_q  <= req_size;
            off_q   <= req_off;
            addr_q  <= {mem_io.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data_i (rdata_q),
        .off_i  (off_q),
        .size_i (size_q),
        .sign_i (sign_q),
        .data_o (ext_data)
    );

    assign mem_io.busy      = (state_q != IDLE);
    assign mem_io.bus_valid = (state_q == BUS);
    assign mem_io.done      = (state_q == RESP) || (state_q == FAULT);
    assign mem_io.err       = (state_q == FAULT) || ((state_q == RESP) && err_q);
    assign mem_io.rdata     = ((state_q == RESP) && !we_q) ? ext_data : '0;
    assign mem_io.bus_we    = we_q;
    assign mem_io.bus_addr  = addr_q;
    assign mem_io.bus_be    = be_q;
    assign mem_io.bus_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_unit.sv
// ============================================================================
// tb_mem_bus_unit : directed + randomized checks of mem_bus_unit (32/64-bit)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_unit;
    import mem_bus_pkg::*;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mem_bus_unit_if #(.XLEN(32)) b32 ();
    mem_bus_unit_if #(.XLEN(64)) b64 ();

    mem_bus_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut32 (.clk(clk), .rst_n(rst_n), .mem_io(b32));
    mem_bus_unit #(.XLEN(64), .TIMEOUT_CYCLES(0))  dut64 (.clk(clk), .rst_n(rst_n), .mem_io(b64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value of the addressed field, zero/sign extended, by plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] brd, input logic [31:0] addr,
                                             input logic [1:0] size, input bit sign);
        longint unsigned v;
        int off, nb;
        off = int'(addr % 4);
        nb  = 8 * (1 << size);
        v   = longint'(brd) / (64'd1 << (8 * off));
        if (nb < 32) begin
            v = v % (64'd1 << nb);
            if (sign && v >= (64'd1 << (nb - 1))) v = v + (64'd1 << 32) - (64'd1 << nb);
        end
        return v[31:0];
    endfunction

    // One complete access on the 32-bit unit; the memory answers after wait_n stall cycles.
    task automatic acc32(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit sign, input int wait_n,
                         input logic [31:0] brd, input bit berr, input bit hold_req);
        int bytes, off;
        bit legal, timed_out, last;
        logic [63:0] be_full, wd_full;
        bytes = 1 << size;
        off   = int'(addr % 4);
        legal = (size != 2'b11) && ((addr % bytes) == 0);
        be_full = ((64'd1 << bytes) - 1) << off;
        wd_full = {32'd0, wdata} << (8 * off);
        b32.req = 1'b1; b32.we = we; b32.addr = addr; b32.wdata = wdata;
        b32.size = size; b32.sign = sign;
        tick();
        if (!hold_req) b32.req = 1'b0;
        b32.addr = $urandom; b32.wdata = $urandom; b32.size = 2'($urandom);
        if (!legal) begin
            chk("fault_done", b32.done, 1);
            chk("fault_err", b32.err, 1);
            chk("fault_rdata", b32.rdata, 0);
            chk("fault_valid", b32.bus_valid, 0);
            b32.req = 1'b0;
            tick();
            chk("fault_end_done", b32.done, 0);
            chk("fault_end_busy", b32.busy, 0);
            chk("fault_end_valid", b32.bus_valid, 0);
            return;
        end
        timed_out = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("bus_valid", b32.bus_valid, 1);
            chk("bus_be", b32.bus_be, be_full[3:0]);
            chk("bus_wdata", b32.bus_wdata, wd_full[31:0]);
            chk("bus_addr", b32.bus_addr, {addr[31:2], 2'b00});
            chk("bus_we", b32.bus_we, we);
            chk("bus_done0", b32.done, 0);
            b32.bus_ready = (k == wait_n);
            b32.bus_rdata = (k == wait_n) ? brd : 32'($urandom);
            b32.bus_err   = (k == wait_n) ? berr : 1'($urandom);
            last = (k == wait_n) || (k == TO - 1);
            timed_out = (k != wait_n);
            tick();
            if (last) break;
        end
        b32.bus_ready = 1'b0;
        b32.req = 1'b0;
        chk("resp_done", b32.done, 1);
        chk("resp_err", b32.err, timed_out ? 1'b1 : berr);
        chk("resp_rdata", b32.rdata, (we || timed_out) ? 32'd0 : ref_load(brd, addr, size, sign));
        chk("resp_valid", b32.bus_valid, 0);
        tick();
        chk("idle_done", b32.done, 0);
        chk("idle_err", b32.err, 0);
        chk("idle_busy", b32.busy, 0);
    endtask

    initial begin
        b32.req = 0; b32.we = 0; b32.addr = 0; b32.wdata = 0; b32.size = 0; b32.sign = 0;
        b32.bus_ready = 0; b32.bus_rdata = 0; b32.bus_err = 0;
        b64.req = 0; b64.we = 0; b64.addr = 0; b64.wdata = 0; b64.size = 0; b64.sign = 0;
        b64.bus_ready = 0; b64.bus_rdata = 0; b64.bus_err = 0;
        tick();
        tick();
        chk("rst_done", b32.done, 0);
        chk("rst_err", b32.err, 0);
        chk("rst_busy", b32.busy, 0);
        chk("rst_valid", b32.bus_valid, 0);
        chk("rst_be", b32.bus_be, 0);
        chk("rst_wdata", b32.bus_wdata, 0);
        chk("rst_addr", b32.bus_addr, 0);
        chk("rst_rdata", b32.rdata, 0);
        rst_n = 1'b1;
        tick();

        // Directed cases
        acc32(0, 32'h100, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 0);
        acc32(0, 32'h103, 0, 2'b00, 1, 0, 32'h80FF_FFFF, 0, 0);
        acc32(0, 32'h103, 0, 2'b00, 0, 0, 32'h80FF_FFFF, 0, 0);
        acc32(1, 32'h202, 32'h1234, 2'b01, 0, 3, 32'h0, 0, 0);
        acc32(0, 32'h101, 0, 2'b10, 0, 0, 32'h0, 0, 0);
        acc32(0, 32'h300, 0, 2'b10, 0, 10, 32'h1111_2222, 0, 0);
        acc32(0, 32'h302, 0, 2'b01, 1, 3, 32'h9876_0000, 0, 0);
        acc32(0, 32'h400, 0, 2'b11, 0, 0, 32'h0, 0, 0);
        acc32(0, 32'h404, 0, 2'b10, 0, 1, 32'hCAFE_F00D, 1, 1);

        // Reset in the middle of a stalled bus access
        b32.req = 1; b32.we = 0; b32.addr = 32'h500; b32.size = 2'b10; b32.sign = 0;
        tick();
        b32.req = 0;
        tick();
        chk("pre_rst_valid", b32.bus_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", b32.bus_valid, 0);
        chk("arst_busy", b32.busy, 0);
        chk("arst_done", b32.done, 0);
        tick();
        chk("arst_done2", b32.done, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", b32.done, 0);
        acc32(0, 32'h600, 0, 2'b10, 0, 1, 32'h0BAD_CAFE, 0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            acc32(1'($urandom), 32'h1000 + 32'($urandom_range(0, 15)), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 5),
                  $urandom, ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        // 64-bit instance: double and upper-word signed access, zero-wait memory
        b64.bus_ready = 1;
        b64.bus_rdata = 64'h0123_4567_89AB_CDEF;
        b64.req = 1; b64.we = 0; b64.addr = 64'h8; b64.size = 2'b11; b64.sign = 1;
        tick();
        b64.req = 0;
        chk("d64_be", b64.bus_be, 8'hFF);
        chk("d64_valid", b64.bus_valid, 1);
        chk("d64_addr", b64.bus_addr, 64'h8);
        tick();
        chk("d64_done", b64.done, 1);
        chk("d64_err", b64.err, 0);
        chk("d64_rdata", b64.rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("d64_idle", b64.done, 0);
        b64.bus_rdata = 64'h8000_0001_0000_0000;
        b64.req = 1; b64.addr = 64'hC; b64.size = 2'b10; b64.sign = 1;
        tick();
        b64.req = 0;
        chk("w64_be", b64.bus_be, 8'hF0);
        tick();
        chk("w64_done", b64.done, 1);
        chk("w64_rdata", b64.rdata, 64'hFFFF_FFFF_8000_0001);
        tick();
        b64.bus_ready = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
